// File: rtl/mul.sv
// Two-stage pipelined 4-bit signed complex multiplier.
// Define MUL_SAT_EN to saturate imaginary overflow to +127; otherwise it wraps to -128.
module mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        ovf
);

  // Sign-extended operand fields
  logic signed [7:0] a_ext, b_ext, c_ext, d_ext;

  assign a_ext = {{4{in1[7]}}, in1[7:4]};
  assign b_ext = {{4{in1[3]}}, in1[3:0]};
  assign c_ext = {{4{in2[7]}}, in2[7:4]};
  assign d_ext = {{4{in2[3]}}, in2[3:0]};

  // Stage 1 state: partial products plus valid
  logic signed [7:0] ac_d, ac_q;
  logic signed [7:0] bd_d, bd_q;
  logic signed [7:0] ad_d, ad_q;
  logic signed [7:0] bc_d, bc_q;
  logic              vld1_d, vld1_q;

  // Stage 2 state: result plus valid
  logic [15:0]       out_d, out_q;
  logic              ovf_d, ovf_q;
  logic              vld2_d, vld2_q;

  logic signed [8:0] re_sum;
  logic signed [8:0] im_sum;
  logic        [7:0] im_res;

  always_comb begin
    ac_d   = ac_q;
    bd_d   = bd_q;
    ad_d   = ad_q;
    bc_d   = bc_q;
    vld1_d = in_valid;
    if (in_valid) begin
      ac_d = a_ext * c_ext;
      bd_d = b_ext * d_ext;
      ad_d = a_ext * d_ext;
      bc_d = b_ext * c_ext;
    end
  end

  always_comb begin
    re_sum = {ac_q[7], ac_q} - {bd_q[7], bd_q};
    im_sum = {ad_q[7], ad_q} + {bc_q[7], bc_q};
    // Only +128 can escape the 8-bit range; the real part never does.
    ovf_d  = ovf_q;
    out_d  = out_q;
    vld2_d = vld1_q;
`ifdef MUL_SAT_EN
    im_res = (im_sum[8] != im_sum[7]) ? 8'h7F : im_sum[7:0];
`else
    im_res = im_sum[7:0];
`endif
    if (vld1_q) begin
      ovf_d = (im_sum[8] != im_sum[7]);
      out_d = {re_sum[7:0], im_res};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q   <= '0;
      bd_q   <= '0;
      ad_q   <= '0;
      bc_q   <= '0;
      vld1_q <= 1'b0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      ac_q   <= ac_d;
      bd_q   <= bd_d;
      ad_q   <= ad_d;
      bc_q   <= bc_d;
      vld1_q <= vld1_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      vld2_q <= vld2_d;
    end
  end

  assign out       = out_q;
  assign ovf       = ovf_q;
  assign out_valid = vld2_q;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for the pipelined complex multiplier.
module tb_mul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [15:0] out;
  logic        out_valid;
  logic        ovf;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [15:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];
  logic [7:0] b2b_in1 [4];
  logic [7:0] b2b_in2 [4];

`ifdef MUL_SAT_EN
  localparam logic [15:0] OvfOut = 16'h007F;
`else
  localparam logic [15:0] OvfOut = 16'h0080;
`endif

  mul u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model built from integer arithmetic on the operand fields
  function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y);
    logic signed [3:0] fa, fb, fc, fd;
    int re, im;
    logic ov;
    fa = x[7:4];
    fb = x[3:0];
    fc = y[7:4];
    fd = y[3:0];
    re = int'(fa) * int'(fc) - int'(fb) * int'(fd);
    im = int'(fa) * int'(fd) + int'(fb) * int'(fc);
    ov = (im > 127);
`ifdef MUL_SAT_EN
    if (ov) im = 127;
`endif
    return {ov, re[7:0], im[7:0]};
  endfunction

  logic [16:0] m;

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;

    vecs[0] = '{8'h11, 8'h01, 16'hFF01, 1'b0};
    vecs[1] = '{8'h37, 8'h81, 16'hE1CB, 1'b0};
    vecs[2] = '{8'hF5, 8'hE2, 16'hF8F4, 1'b0};
    vecs[3] = '{8'hFF, 8'h5A, 16'hF501, 1'b0};
    vecs[4] = '{8'h88, 8'h88, OvfOut,   1'b1};
    vecs[5] = '{8'h77, 8'h77, 16'h0062, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 16'h4000, 1'b0};
    vecs[7] = '{8'h08, 8'h08, 16'hC000, 1'b0};

    b2b_in1[0] = 8'h12; b2b_in2[0] = 8'h34;
    b2b_in1[1] = 8'h88; b2b_in2[1] = 8'h88;
    b2b_in1[2] = 8'hF5; b2b_in2[2] = 8'hE2;
    b2b_in1[3] = 8'h7A; b2b_in2[3] = 8'h96;

    repeat (2) @(negedge clk);
    check("reset out", out, 16'h0000);
    check("reset out_valid", {15'd0, out_valid}, 16'd0);
    check("reset ovf", {15'd0, ovf}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-shot vectors: latency, result and hold-while-idle
    for (int i = 0; i < 8; i++) begin
      in1      = vecs[i].in1;
      in2      = vecs[i].in2;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in1      = ~vecs[i].in1;
      in2      = ~vecs[i].in2;
      check($sformatf("vec%0d valid after 1 edge", i), {15'd0, out_valid}, 16'd0);
      @(negedge clk);
      check($sformatf("vec%0d valid after 2 edges", i), {15'd0, out_valid}, 16'd1);
      check($sformatf("vec%0d out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d ovf", i), {15'd0, ovf}, {15'd0, vecs[i].exp_ovf});
      @(negedge clk);
      check($sformatf("vec%0d valid drop", i), {15'd0, out_valid}, 16'd0);
      check($sformatf("vec%0d out hold", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d ovf hold", i), {15'd0, ovf}, {15'd0, vecs[i].exp_ovf});
    end

    // Back-to-back: four pairs on consecutive cycles
    for (int t = 0; t < 6; t++) begin
      if (t >= 2) begin
        m = model(b2b_in1[t-2], b2b_in2[t-2]);
        check($sformatf("b2b%0d valid", t - 2), {15'd0, out_valid}, 16'd1);
        check($sformatf("b2b%0d out", t - 2), out, m[15:0]);
        check($sformatf("b2b%0d ovf", t - 2), {15'd0, ovf}, {15'd0, m[16]});
      end
      if (t < 4) begin
        in1      = b2b_in1[t];
        in2      = b2b_in2[t];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b valid drop", {15'd0, out_valid}, 16'd0);

    // Reset while two results are in flight
    in1      = 8'h88;
    in2      = 8'h88;
    in_valid = 1'b1;
    @(negedge clk);
    in1      = 8'h37;
    in2      = 8'h81;
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight valid", {15'd0, out_valid}, 16'd1);
    check("inflight ovf", {15'd0, ovf}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out", out, 16'h0000);
    check("async rst out_valid", {15'd0, out_valid}, 16'd0);
    check("async rst ovf", {15'd0, ovf}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post rst idle%0d valid", k), {15'd0, out_valid}, 16'd0);
      check($sformatf("post rst idle%0d out", k), out, 16'h0000);
    end

    in1      = 8'hFF;
    in2      = 8'h5A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post rst valid after 1 edge", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    check("post rst valid after 2 edges", {15'd0, out_valid}, 16'd1);
    check("post rst out", out, 16'hF501);
    check("post rst ovf", {15'd0, ovf}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
